// File: rtl/mem_bus_arbiter2_pkg.sv
// Shared types and constants for the two-master memory/IO bus arbiter.
package mem_bus_pkg;

    // Sequencer states for one bus transaction.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StAddr = 2'b01,
        StWait = 2'b10,
        StDone = 2'b11
    } state_e;

    // Wait counter width.
    localparam int unsigned WW = 4;

    // Default extra cycles per decoded region.
    localparam int unsigned DEF_LOMEM_WAIT = 0;
    localparam int unsigned DEF_PMON_WAIT  = 0;
    localparam int unsigned DEF_HIMEM_WAIT = 2;
    localparam int unsigned DEF_IO_WAIT    = 1;
    localparam int unsigned DEF_SIMIF_WAIT = 0;

    // Master indices: m0 = CPU, m1 = DMA/debug monitor.
    localparam int unsigned M0 = 0;
    localparam int unsigned M1 = 1;

    // True when a wait count can be loaded into a ww-bit counter.
    function automatic bit wait_fits(input int unsigned w, input int unsigned ww);
        return (ww >= 1) && (ww <= 31) && (w <= ((32'd1 << ww) - 32'd1));
    endfunction

endpackage

// File: rtl/mem_bus_arbiter2_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins; on contention the master that did not
// own the bus last wins. Purely combinational so other bus masters can reuse it.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    output logic [1:0] o_gnt
);
    import mem_bus_pkg::*;

    // One-hot grant from the request pair and the previous owner.
    always_comb begin
        o_gnt = 2'b00;
        unique case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (i_last_owner == 1'(M1)) ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter2.sv
// Two-master arbiter and access sequencer in front of the bus address decoder.
// One transaction at a time: grant, drive the registered address, add the wait states of
// the selected region, then pulse ack with the captured read data.
module mem_bus_arbiter2 #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned WW         = mem_bus_pkg::WW,
    parameter int unsigned LOMEM_WAIT = mem_bus_pkg::DEF_LOMEM_WAIT,
    parameter int unsigned PMON_WAIT  = mem_bus_pkg::DEF_PMON_WAIT,
    parameter int unsigned HIMEM_WAIT = mem_bus_pkg::DEF_HIMEM_WAIT,
    parameter int unsigned IO_WAIT    = mem_bus_pkg::DEF_IO_WAIT,
    parameter int unsigned SIMIF_WAIT = mem_bus_pkg::DEF_SIMIF_WAIT
) (
    input  logic          clk,
    input  logic          reset,
    // master 0 (CPU)
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_wen,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [DW-1:0] m0_rdata,
    // master 1 (DMA / debug monitor)
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_wen,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] m1_rdata,
    // shared bus
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic          bus_en,
    output logic          bus_wen,
    input  logic [DW-1:0] bus_rdata,
    // decoder selects
    input  logic          cs_lomem,
    input  logic          cs_pmon,
    input  logic          cs_himem,
    input  logic          cs_simif,
    input  logic [15:0]   cs_io,
    // current owner
    output logic [1:0]    gnt
);
    import mem_bus_pkg::*;

    // Every wait count must fit the WW-bit counter.
    if (!wait_fits(LOMEM_WAIT, WW) || !wait_fits(PMON_WAIT, WW) ||
        !wait_fits(HIMEM_WAIT, WW) || !wait_fits(IO_WAIT, WW) ||
        !wait_fits(SIMIF_WAIT, WW)) begin : g_wait_range_check
        $fatal(1, "mem_bus_arbiter2: a wait parameter does not fit in WW bits");
    end

    state_e        r_state;
    logic          r_last_owner;
    logic [1:0]    r_gnt;
    logic [AW-1:0] r_bus_addr;
    logic [DW-1:0] r_bus_wdata;
    logic          r_wen;
    logic          r_bus_en;
    logic          r_bus_wen;
    logic [WW-1:0] r_cnt;
    logic [1:0]    r_ack;
    logic [1:0]    r_err;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic [1:0]    w_pick;
    logic          w_mapped;
    logic [WW-1:0] w_wait;
    logic          w_finish;
    logic          w_unmapped;
    logic [DW-1:0] w_cap;

    rr_arb2 u_rr_arb2 (
        .i_req        ({m1_req, m0_req}),
        .i_last_owner (r_last_owner),
        .o_gnt        (w_pick)
    );

    // Wait count of the selected region, highest-priority select first.
    always_comb begin
        w_wait = WW'(LOMEM_WAIT);
        if (cs_simif) begin
            w_wait = WW'(SIMIF_WAIT);
        end else if (|cs_io) begin
            w_wait = WW'(IO_WAIT);
        end else if (cs_himem) begin
            w_wait = WW'(HIMEM_WAIT);
        end else if (cs_pmon) begin
            w_wait = WW'(PMON_WAIT);
        end else begin
            w_wait = WW'(LOMEM_WAIT);
        end
    end

    assign w_mapped = cs_simif | (|cs_io) | cs_himem | cs_pmon | cs_lomem;

    // Last bus_en cycle of the access: unmapped or zero-wait in ADDR, or counter drained.
    always_comb begin
        w_finish = 1'b0;
        unique case (r_state)
            StAddr:  w_finish = !w_mapped || (w_wait == '0);
            StWait:  w_finish = (r_cnt == '0);
            default: w_finish = 1'b0;
        endcase
    end

    assign w_unmapped = (r_state == StAddr) && !w_mapped;
    assign w_cap      = w_unmapped ? '0 : bus_rdata;

    // Transaction sequencer with all bus and master outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_last_owner <= 1'(M1);
            r_gnt        <= '0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_wen        <= 1'b0;
            r_bus_en     <= 1'b0;
            r_bus_wen    <= 1'b0;
            r_cnt        <= '0;
            r_ack        <= '0;
            r_err        <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_ack <= '0;
            r_err <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_pick != 2'b00) begin
                        r_gnt        <= w_pick;
                        r_last_owner <= w_pick[1];
                        r_bus_addr   <= w_pick[1] ? m1_addr : m0_addr;
                        r_bus_wdata  <= w_pick[1] ? m1_wdata : m0_wdata;
                        r_wen        <= w_pick[1] ? m1_wen : m0_wen;
                        r_bus_wen    <= w_pick[1] ? m1_wen : m0_wen;
                        r_bus_en     <= 1'b1;
                        r_state      <= StAddr;
                    end
                end
                StAddr: begin
                    if (w_finish) begin
                        r_state <= StDone;
                    end else begin
                        r_cnt   <= w_wait - WW'(1);
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (w_finish) begin
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt - WW'(1);
                    end
                end
                StDone: begin
                    r_gnt   <= '0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase

            // Close the access: drop the strobes, pulse ack to the owner, keep read data.
            if (w_finish) begin
                r_bus_en  <= 1'b0;
                r_bus_wen <= 1'b0;
                r_ack     <= r_gnt;
                r_err     <= w_unmapped ? r_gnt : 2'b00;
                if (!r_wen) begin
                    if (r_gnt[1]) begin
                        r_rdata1 <= w_cap;
                    end else begin
                        r_rdata0 <= w_cap;
                    end
                end
            end
        end
    end

    assign gnt       = r_gnt;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_en    = r_bus_en;
    assign bus_wen   = r_bus_wen;
    assign m0_ack    = r_ack[0];
    assign m1_ack    = r_ack[1];
    assign m0_err    = r_err[0];
    assign m1_err    = r_err[1];
    assign m0_rdata  = r_rdata0;
    assign m1_rdata  = r_rdata1;

endmodule

// File: tb/tb_mem_bus_arbiter2.sv
// Bench for mem_bus_arbiter2: transaction-timeline model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_mem_bus_arbiter2;

    localparam int RG_LOMEM = 0;
    localparam int RG_PMON  = 1;
    localparam int RG_HIMEM = 2;
    localparam int RG_SIMIF = 3;
    localparam int RG_IO    = 4;
    localparam int RG_NONE  = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic        m0_wen = 1'b0, m1_wen = 1'b0;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_en, bus_wen;
    logic [31:0] tb_rdata = '0;
    logic        cs_lomem, cs_pmon, cs_himem, cs_simif;
    logic [15:0] cs_io;
    logic [1:0]  gnt;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Address map of the environment: top nibble picks the region, io bit from addr[3:0].
    function automatic int region_of(input logic [31:0] a);
        case (a[31:28])
            4'h0:    return RG_LOMEM;
            4'h1:    return RG_PMON;
            4'h2:    return RG_HIMEM;
            4'h3:    return RG_SIMIF;
            4'h4:    return RG_IO;
            default: return RG_NONE;
        endcase
    endfunction

    function automatic int wait_of(input int rg);
        case (rg)
            RG_HIMEM: return 2;
            RG_IO:    return 1;
            default:  return 0;
        endcase
    endfunction

    assign cs_lomem = (region_of(bus_addr) == RG_LOMEM);
    assign cs_pmon  = (region_of(bus_addr) == RG_PMON);
    assign cs_himem = (region_of(bus_addr) == RG_HIMEM);
    assign cs_simif = (region_of(bus_addr) == RG_SIMIF);
    assign cs_io    = (region_of(bus_addr) == RG_IO) ? (16'h0001 << bus_addr[3:0]) : 16'h0000;

    mem_bus_arbiter2 dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wen    (m0_wen),
        .m0_ack    (m0_ack),
        .m0_err    (m0_err),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wen    (m1_wen),
        .m1_ack    (m1_ack),
        .m1_err    (m1_err),
        .m1_rdata  (m1_rdata),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_en    (bus_en),
        .bus_wen   (bus_wen),
        .bus_rdata (tb_rdata),
        .cs_lomem  (cs_lomem),
        .cs_pmon   (cs_pmon),
        .cs_himem  (cs_himem),
        .cs_simif  (cs_simif),
        .cs_io     (cs_io),
        .gnt       (gnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Model: each granted transaction occupies a timeline of cycles counted from its grant.
    int          mdl_owner = 0, mdl_k = 0, mdl_w = 0, mdl_pick = 0;
    logic        mdl_busy = 1'b0, mdl_last = 1'b1, mdl_mapped = 1'b0, mdl_wen = 1'b0;
    logic [1:0]  exp_gnt = '0, exp_ack = '0, exp_err = '0;
    logic        exp_en = 1'b0, exp_wen = 1'b0;
    logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rd0 = '0, exp_rd1 = '0, mdl_v = '0;

    always @(posedge clk) begin
        if (reset) begin
            mdl_busy = 1'b0; mdl_last = 1'b1;
            exp_gnt = '0; exp_ack = '0; exp_err = '0; exp_en = 1'b0; exp_wen = 1'b0;
            exp_addr = '0; exp_wdata = '0; exp_rd0 = '0; exp_rd1 = '0;
        end else begin
            exp_ack = '0;
            exp_err = '0;
            if (!mdl_busy) begin
                mdl_pick = -1;
                if (m0_req && m1_req) mdl_pick = mdl_last ? 0 : 1;
                else if (m0_req)      mdl_pick = 0;
                else if (m1_req)      mdl_pick = 1;
                if (mdl_pick >= 0) begin
                    mdl_busy   = 1'b1;
                    mdl_k      = 0;
                    mdl_owner  = mdl_pick;
                    mdl_last   = (mdl_pick == 1);
                    exp_addr   = (mdl_pick == 1) ? m1_addr : m0_addr;
                    exp_wdata  = (mdl_pick == 1) ? m1_wdata : m0_wdata;
                    mdl_wen    = (mdl_pick == 1) ? m1_wen : m0_wen;
                    mdl_mapped = (region_of(exp_addr) != RG_NONE);
                    mdl_w      = mdl_mapped ? wait_of(region_of(exp_addr)) : 0;
                    exp_gnt    = (mdl_pick == 1) ? 2'b10 : 2'b01;
                    exp_en     = 1'b1;
                    exp_wen    = mdl_wen;
                end
            end else begin
                mdl_k++;
                if (mdl_k == mdl_w + 1) begin
                    exp_en = 1'b0;
                    exp_wen = 1'b0;
                    exp_ack[mdl_owner] = 1'b1;
                    exp_err[mdl_owner] = !mdl_mapped;
                    if (!mdl_wen) begin
                        mdl_v = mdl_mapped ? tb_rdata : 32'h0;
                        if (mdl_owner == 1) exp_rd1 = mdl_v;
                        else                exp_rd0 = mdl_v;
                    end
                end else if (mdl_k == mdl_w + 2) begin
                    mdl_busy = 1'b0;
                    exp_gnt = '0;
                end
            end
        end
        #1;
        chk("gnt", gnt, exp_gnt);
        chk("bus_en", bus_en, exp_en);
        chk("bus_wen", bus_wen, exp_wen);
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_wdata", bus_wdata, exp_wdata);
        chk("ack", {m1_ack, m0_ack}, exp_ack);
        chk("err", {m1_err, m0_err}, exp_err);
        chk("m0_rdata", m0_rdata, exp_rd0);
        chk("m1_rdata", m1_rdata, exp_rd1);
        chk("ack_exclusive", m0_ack & m1_ack, 0);
    end

    // One master transaction; returns cycles from the sampling edge to ack and strobe counts.
    task automatic txn(input int m, input logic [31:0] a, input logic [31:0] d, input logic w,
                       output int lat, output int en_cyc, output int wen_cyc,
                       output logic [31:0] rd, output logic er);
        bit done;
        @(negedge clk);
        if (m == 1) begin
            m1_addr = a; m1_wdata = d; m1_wen = w; m1_req = 1'b1;
        end else begin
            m0_addr = a; m0_wdata = d; m0_wen = w; m0_req = 1'b1;
        end
        lat = 0; en_cyc = 0; wen_cyc = 0; rd = '0; er = 1'b0; done = 1'b0;
        while (!done) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus_en) en_cyc++;
            if (bus_wen) wen_cyc++;
            if ((m == 1) ? m1_ack : m0_ack) begin
                done = 1'b1;
                rd = (m == 1) ? m1_rdata : m0_rdata;
                er = (m == 1) ? m1_err : m0_err;
            end else if (lat > 50) begin
                n_cmp++; n_fail++;
                $display("FAIL txn_timeout m%0d: got no ack, expected ack within 50 cycles", m);
                done = 1'b1;
            end
        end
        @(negedge clk);
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, en_c, wen_c, ng, n0, cyc, acks;
        logic [31:0] rd;
        logic        er;
        logic [1:0]  prev;
        logic [1:0]  seq [3];
        int          t [3];

        @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_bus_en", bus_en, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        @(negedge clk);
        reset = 1'b0;

        // Contention right after reset: m0, m1, m0.
        m0_addr = 32'h0000_0010; m0_wen = 1'b0;
        m1_addr = 32'h1000_0020; m1_wen = 1'b0;
        tb_rdata = 32'h0BAD_F00D;
        m0_req = 1'b1; m1_req = 1'b1;
        ng = 0; n0 = 0; cyc = 0; prev = 2'b00;
        while (n0 < 2 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (gnt != 2'b00 && prev == 2'b00 && ng < 3) begin
                seq[ng] = gnt;
                ng++;
            end
            prev = gnt;
            if (m0_ack) n0++;
            if (m1_ack) begin
                @(negedge clk);
                m1_req = 1'b0;
            end
        end
        @(negedge clk);
        m0_req = 1'b0;
        chk("rr_grants", ng, 3);
        chk("rr_first", seq[0], 2'b01);
        chk("rr_second", seq[1], 2'b10);
        chk("rr_third", seq[2], 2'b01);
        chk("rr_m1_rdata", m1_rdata, 32'h0BAD_F00D);
        repeat (2) @(negedge clk);

        // Single m0 read from lomem.
        tb_rdata = 32'hDEAD_BEEF;
        txn(0, 32'h0000_0040, 32'h0, 1'b0, lat, en_c, wen_c, rd, er);
        chk("rd_latency", lat, 2);
        chk("rd_en_cycles", en_c, 1);
        chk("rd_rdata", rd, 32'hDEAD_BEEF);
        chk("rd_err", er, 0);

        // m1 write to himem, two waits.
        tb_rdata = 32'h7777_7777;
        txn(1, 32'h2000_0100, 32'h1234_5678, 1'b1, lat, en_c, wen_c, rd, er);
        chk("wr_latency", lat, 4);
        chk("wr_en_cycles", en_c, 3);
        chk("wr_wen_cycles", wen_c, 3);
        chk("wr_bus_wdata", bus_wdata, 32'h1234_5678);
        chk("wr_m1_rdata_kept", rd, 32'h0BAD_F00D);

        // Unmapped read.
        tb_rdata = 32'h55AA_55AA;
        txn(0, 32'hF000_0000, 32'h0, 1'b0, lat, en_c, wen_c, rd, er);
        chk("unmap_latency", lat, 2);
        chk("unmap_err", er, 1);
        chk("unmap_rdata", rd, 32'h0);

        // IO read aborted by reset in WAIT, then retried.
        @(negedge clk);
        tb_rdata = 32'hCAFE_F00D;
        m0_addr = 32'h4000_0003; m0_wen = 1'b0; m0_req = 1'b1;
        @(posedge clk);
        #1;
        chk("io_grant", gnt, 2'b01);
        @(posedge clk);
        #1;
        chk("io_wait_en", bus_en, 1);
        @(negedge clk);
        reset = 1'b1;
        m0_req = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_gnt", gnt, 2'b00);
        chk("abort_en", bus_en, 0);
        chk("abort_addr", bus_addr, 32'h0);
        chk("abort_ack", m0_ack, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_no_ack", m0_ack, 0);
        end
        txn(0, 32'h4000_0003, 32'h0, 1'b0, lat, en_c, wen_c, rd, er);
        chk("io_latency", lat, 3);
        chk("io_en_cycles", en_c, 2);
        chk("io_rdata", rd, 32'hCAFE_F00D);

        // m0 holds req: three zero-wait accesses, three cycles apart.
        @(negedge clk);
        tb_rdata = 32'hA1B2_C3D4;
        m0_addr = 32'h0000_0100; m0_wen = 1'b0; m0_req = 1'b1;
        acks = 0; cyc = 0;
        while (acks < 3 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (m0_ack) begin
                t[acks] = cyc;
                acks++;
            end
        end
        @(negedge clk);
        m0_req = 1'b0;
        chk("b2b_count", acks, 3);
        chk("b2b_first", t[0], 2);
        chk("b2b_gap1", t[1] - t[0], 3);
        chk("b2b_gap2", t[2] - t[1], 3);
        chk("b2b_rdata", m0_rdata, 32'hA1B2_C3D4);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter2.md
Name: mem_bus_arbiter2

Overview:
Two-master arbiter and access sequencer for the shared memory/IO bus in front of the address decoder.
- Masters: m0 = CPU, m1 = DMA/debug monitor.
- Picks one master per transaction, round-robin on contention.
- Drives the registered bus address into the decoder and reads back its chip selects.
- Inserts per-region wait states, then returns a one-cycle ack with captured read data.

Parameters:
AW, 32, address width
DW, 32, data width
WW, 4, wait counter width
LOMEM_WAIT, 0, extra cycles for cs_lomem
PMON_WAIT, 0, extra cycles for cs_pmon
HIMEM_WAIT, 2, extra cycles for cs_himem
IO_WAIT, 1, extra cycles for any cs_io bit
SIMIF_WAIT, 0, extra cycles for cs_simif

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_req / m1_req  in  1  request; held with addr/wdata/wen until ack
m0_addr / m1_addr  in  AW  request address
m0_wdata / m1_wdata  in  DW  write data
m0_wen / m1_wen  in  1  1=write, 0=read
m0_ack / m1_ack  out  1  one-cycle completion pulse
m0_err / m1_err  out  1  valid with ack; unmapped address
m0_rdata / m1_rdata  out  DW  read data, valid with ack, held until next ack
bus_addr  out  AW  registered address to decoder and targets
bus_wdata  out  DW  registered write data
bus_en  out  1  access strobe
bus_wen  out  1  write strobe (= latched wen & bus_en)
bus_rdata  in  DW  target read data
cs_lomem, cs_pmon, cs_himem, cs_simif  in  1  decoder selects
cs_io  in  16  decoder IO selects
gnt  out  2  one-hot current owner (00 when idle)

Behaviour:
- Reset: state=IDLE; all outputs 0; last_owner=m1, so m0 wins the first contention.
- Reset mid-transaction aborts it: no ack is issued and the master must re-request.
- States: IDLE, ADDR, WAIT, DONE.
- IDLE, no requests: stay.
- IDLE, exactly one req: grant it.
- IDLE, both req: grant the master that is not last_owner.
- On grant: latch addr/wdata/wen into bus regs, set gnt, set last_owner, go to ADDR.
- ADDR: bus_en=1. Decoder outputs are sampled this cycle.
  - Wait count W comes from the selected region: simif, io, himem, pmon, lomem (in that priority).
  - If W==0: capture bus_rdata into the owner's rdata, go to DONE.
  - Else: cnt=W-1, go to WAIT.
- No chip select active: unmapped. Capture rdata=0, set err, go to DONE with no waits.
- WAIT: bus_en=1.
  - cnt==0: capture bus_rdata, go to DONE.
  - Otherwise decrement cnt.
- DONE: bus_en=0; owner ack=1 (and err if unmapped); gnt cleared at the edge leaving DONE; next state IDLE.
- Timing: req sampled at edge E gives bus_en for 1+W cycles starting at E+1, and ack in the cycle after E+1+W. Zero-wait latency is 2 cycles; no back-to-back grants without an IDLE cycle.
- Master contract: drop req (or present a new request) in the cycle after ack. A req still high in IDLE is treated as a new request.
- The non-owner's req is ignored mid-transaction and is served next; it does not starve.
- ack/err are never asserted for both masters in the same cycle.
- Writes: bus_wen stays high for every bus_en cycle; rdata is not updated on writes.
- Wait counter width: WW bits; parameters above 2^WW-1 are illegal (checked by an elaboration assertion).

Decomposition:
- Package mem_bus_pkg:
  - state enum (IDLE, ADDR, WAIT, DONE)
  - WW
  - default wait constants
  - master index constants M0=0, M1=1
- Sub-module rr_arb2:
  - Combinational 2-way round-robin pick from req[1:0] and last_owner, returning a one-hot grant.
  - Reused by future bus masters.

Test Plan:
- Single m0 read, cs_lomem, bus_rdata=32'hDEADBEEF -> bus_en 1 cycle; m0_ack 2 cycles after req sampled; m0_rdata=DEADBEEF; m0_err=0.
- m1 write to himem (HIMEM_WAIT=2), wdata=32'h12345678 -> bus_en and bus_wen high 3 cycles; bus_wdata=12345678; m1_ack in the 4th cycle after grant; m1_rdata unchanged.
- m0_req and m1_req rise together after reset, both held -> m0 served first, then m1, then m0; gnt alternates 01,10,01; never both acks.
- Read with no cs asserted (unmapped address) -> ack after 2 cycles, err=1, rdata=0.
- IO read (IO_WAIT=1) with reset pulsed during WAIT -> all outputs 0 next cycle, no ack; re-request completes normally.
- m0 holds req high after ack for 3 transactions, m1 idle -> three back-to-back zero-wait accesses, each 3 cycles (ADDR, DONE, IDLE).
